// File: rtl/credit_warn_reader.sv
// -----------------------------------------------------------------------------
// credit_warn_reader
//
// Reader side of the credit-system low-balance warning list. On start it owns
// the credit block's command port. It drives mode 3 with the latched threshold
// and collects the one-ID-per-clock idOutput stream until endOfListWar. Then it
// drives one mode-0 cycle so the credit block clears its per-student listed
// flags. Finally it presents the warned set as a bitmask plus a count.
//
// Ports:
//   CLK           clock, all logic on the rising edge
//   RST_N         synchronous active-low reset
//   start         begin a list read (sampled only in IDLE)
//   threshold     credit threshold, latched at start
//   idOutput      registered list ID from the credit block, 0 = none
//   endOfListWar  end-of-list flag from the credit block
//   mode          command mode to the credit block
//   credit        credit/threshold to the credit block
//   studentID     tied to 0 (ID 0 never registers in mode 0)
//   incTime       tied to 0
//   busy          high while in LIST or CLEAR
//   done          one-cycle pulse when a read completes
//   warnMask      bit i-1 set if student i was listed
//   warnCount     number of distinct listed students
//   dupErr        an already-set ID was reported again
//   timeoutErr    no end flag within TIMEOUT valid samples
// -----------------------------------------------------------------------------
module credit_warn_reader #(
   parameter int TIMEOUT = 9
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       start,
   input  logic [2:0] threshold,
   input  logic [2:0] idOutput,
   input  logic       endOfListWar,
   output logic [1:0] mode,
   output logic [2:0] credit,
   output logic [2:0] studentID,
   output logic       incTime,
   output logic       busy,
   output logic       done,
   output logic [6:0] warnMask,
   output logic [2:0] warnCount,
   output logic       dupErr,
   output logic       timeoutErr
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LIST  = 2'd1,
      S_CLEAR = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state, w_state_next;
   logic [1:0]      r_mode, w_mode_next;
   logic [2:0]      r_credit, w_credit_next;
   logic            r_busy, w_busy_next;
   logic            r_done, w_done_next;
   logic [6:0]      r_mask, w_mask_next;
   logic [2:0]      r_count, w_count_next;
   logic            r_dup, w_dup_next;
   logic            r_to, w_to_next;
   logic            r_skip, w_skip_next;
   logic [CW-1:0]   r_samples, w_samples_next;

   // One-hot decode of the reported ID; all zero when idOutput is 0.
   logic [6:0]      w_id_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_id_dec
         assign w_id_onehot[gi] = (idOutput == 3'(gi + 1));
      end
   endgenerate

   always_comb begin
      w_state_next   = r_state;
      w_mode_next    = r_mode;
      w_credit_next  = r_credit;
      w_mask_next    = r_mask;
      w_count_next   = r_count;
      w_dup_next     = r_dup;
      w_to_next      = r_to;
      w_skip_next    = r_skip;
      w_samples_next = r_samples;

      case (r_state)
         S_IDLE: begin
            // Driving mode 0 continuously keeps the credit block's listed
            // flags clear, including any leftovers from an aborted read.
            w_mode_next   = 2'd0;
            w_credit_next = 3'd0;
            if (start) begin
               w_state_next   = S_LIST;
               w_mode_next    = 2'd3;
               w_credit_next  = threshold;
               w_mask_next    = 7'd0;
               w_count_next   = 3'd0;
               w_dup_next     = 1'b0;
               w_to_next      = 1'b0;
               w_samples_next = '0;
               w_skip_next    = 1'b1;
            end
         end

         S_LIST: begin
            if (r_skip) begin
               // The credit block is still presenting its prior mode-0
               // result on this edge, so nothing here is a list sample.
               w_skip_next = 1'b0;
            end else if (endOfListWar) begin
               w_state_next  = S_CLEAR;
               w_mode_next   = 2'd0;
               w_credit_next = 3'd0;
            end else if (r_samples == CW'(TIMEOUT)) begin
               w_to_next     = 1'b1;
               w_state_next  = S_CLEAR;
               w_mode_next   = 2'd0;
               w_credit_next = 3'd0;
            end else begin
               w_samples_next = r_samples + CW'(1);
               if (|w_id_onehot) begin
                  if (|(w_id_onehot & r_mask)) begin
                     w_dup_next = 1'b1;
                  end else begin
                     w_mask_next  = r_mask | w_id_onehot;
                     w_count_next = r_count + 3'd1;
                  end
               end
            end
         end

         S_CLEAR: begin
            // mode is already 0; holding it for this edge lets the credit
            // block clear its flags before the result is announced.
            w_state_next = S_DONE;
         end

         S_DONE: begin
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      w_busy_next = (w_state_next == S_LIST) || (w_state_next == S_CLEAR);
      w_done_next = (w_state_next == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         r_mode    <= 2'd0;
         r_credit  <= 3'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mask    <= 7'd0;
         r_count   <= 3'd0;
         r_dup     <= 1'b0;
         r_to      <= 1'b0;
         r_skip    <= 1'b0;
         r_samples <= '0;
      end else begin
         r_state   <= w_state_next;
         r_mode    <= w_mode_next;
         r_credit  <= w_credit_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_mask    <= w_mask_next;
         r_count   <= w_count_next;
         r_dup     <= w_dup_next;
         r_to      <= w_to_next;
         r_skip    <= w_skip_next;
         r_samples <= w_samples_next;
      end
   end

   assign mode       = r_mode;
   assign credit     = r_credit;
   assign studentID  = 3'd0;
   assign incTime    = 1'b0;
   assign busy       = r_busy;
   assign done       = r_done;
   assign warnMask   = r_mask;
   assign warnCount  = r_count;
   assign dupErr     = r_dup;
   assign timeoutErr = r_to;

endmodule

// File: tb/tb_credit_warn_reader.sv
// -----------------------------------------------------------------------------
// Bench for credit_warn_reader. A behavioural credit block (students with
// credits and listed flags) or a scripted stub stream answers the reader's
// mode-3 commands; expected results come from the warning rules directly.
// -----------------------------------------------------------------------------
module tb_credit_warn_reader;

   localparam int TIMEOUT = 9;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       start = 1'b0;
   logic [2:0] threshold = 3'd0;
   logic [2:0] idOutput = 3'd0;
   logic       endOfListWar = 1'b0;
   logic [1:0] mode;
   logic [2:0] credit;
   logic [2:0] studentID;
   logic       incTime;
   logic       busy;
   logic       done;
   logic [6:0] warnMask;
   logic [2:0] warnCount;
   logic       dupErr;
   logic       timeoutErr;

   int n_checks = 0;
   int n_errors = 0;

   credit_warn_reader #(.TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .threshold(threshold),
      .idOutput(idOutput), .endOfListWar(endOfListWar),
      .mode(mode), .credit(credit), .studentID(studentID), .incTime(incTime),
      .busy(busy), .done(done), .warnMask(warnMask), .warnCount(warnCount),
      .dupErr(dupErr), .timeoutErr(timeoutErr)
   );

   always #5 CLK = ~CLK;

   // ---------------- credit block model / stub stream ----------------
   bit         use_stub = 1'b0;
   logic [6:0] reg_mask = 7'd0;
   logic [2:0] cred [1:7];
   logic [6:0] listed = 7'd0;
   logic [3:0] stub_q [$];      // {end, id}
   logic [2:0] stub_fill = 3'd0;

   // Lowest registered, not-yet-listed student whose credit is below thr.
   function automatic logic [2:0] pick(input logic [2:0] thr);
      for (int i = 1; i <= 7; i++)
         if (reg_mask[i-1] && cred[i] < thr && !listed[i-1]) return 3'(i);
      return 3'd0;
   endfunction

   always @(posedge CLK) begin
      if (mode == 2'd3) begin
         if (use_stub) begin
            if (stub_q.size() > 0) begin
               {endOfListWar, idOutput} <= stub_q.pop_front();
            end else begin
               idOutput     <= stub_fill;
               endOfListWar <= 1'b0;
            end
         end else if (pick(credit) != 3'd0) begin
            idOutput     <= pick(credit);
            endOfListWar <= 1'b0;
            listed[3'(pick(credit) - 3'd1)] <= 1'b1;
         end else begin
            idOutput     <= 3'd0;
            endOfListWar <= 1'b1;
         end
      end else begin
         listed       <= 7'd0;
         idOutput     <= 3'd0;
         endOfListWar <= 1'b0;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mode"}, mode, 0);
      check({tag, "_credit"}, credit, 0);
      check({tag, "_studentID"}, studentID, 0);
      check({tag, "_incTime"}, incTime, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_mask"}, warnMask, 0);
      check({tag, "_count"}, warnCount, 0);
      check({tag, "_dup"}, dupErr, 0);
      check({tag, "_to"}, timeoutErr, 0);
   endtask

   // One full read: start is held for two edges (second must be ignored),
   // threshold is scrambled after acceptance (must stay latched).
   task automatic run_read(input string tag, input logic [2:0] thr,
                           input logic [6:0] e_mask, input logic [2:0] e_cnt,
                           input logic e_dup, input logic e_to, input int e_lat);
      int got = 0;
      @(negedge CLK);
      start = 1'b1;
      threshold = thr;
      @(posedge CLK); #1;
      check({tag, "_busy_e0"}, busy, 1);
      check({tag, "_mode_e0"}, mode, 3);
      check({tag, "_credit_e0"}, credit, thr);
      for (int n = 1; n <= e_lat + 4; n++) begin
         @(posedge CLK); #1;
         start = 1'b0;
         threshold = 3'($urandom);
         if (done) begin
            got = n;
            break;
         end
         if (n < e_lat) check({tag, "_busy"}, busy, 1);
      end
      check({tag, "_latency"}, got, e_lat);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_mask"}, warnMask, e_mask);
      check({tag, "_count"}, warnCount, e_cnt);
      check({tag, "_dup"}, dupErr, e_dup);
      check({tag, "_to"}, timeoutErr, e_to);
      @(posedge CLK); #1;
      check({tag, "_done_pulse"}, done, 0);
      $display("read %s thr=%0d mask=%b count=%0d dup=%0d to=%0d latency=%0d",
               tag, thr, warnMask, warnCount, dupErr, timeoutErr, got);
   endtask

   // Credit-block read: warned set is every registered student below thr.
   task automatic credit_read(input string tag, input logic [2:0] thr);
      logic [6:0] m = 7'd0;
      for (int i = 1; i <= 7; i++)
         if (reg_mask[i-1] && cred[i] < thr) m[i-1] = 1'b1;
      use_stub = 1'b0;
      run_read(tag, thr, m, 3'($countones(m)), 1'b0, 1'b0, $countones(m) + 3);
   endtask

   // Stub read: list of raw IDs followed by an end flag.
   task automatic stub_read(input string tag, input int len);
      logic [6:0] m = 7'd0;
      logic       d = 1'b0;
      logic [2:0] id;
      int         seen;
      stub_q.delete();
      stub_fill = 3'd0;
      seen = (len > TIMEOUT) ? TIMEOUT : len;
      for (int j = 0; j < len; j++) begin
         id = 3'($urandom_range(0, 7));
         stub_q.push_back({1'b0, id});
         if (j < seen && id != 3'd0) begin
            if (m[id-1]) d = 1'b1;
            m[id-1] = 1'b1;
         end
      end
      stub_q.push_back(4'b1000);
      use_stub = 1'b1;
      run_read(tag, 3'($urandom), m, 3'($countones(m)), d, (len > TIMEOUT),
               (len > TIMEOUT) ? TIMEOUT + 3 : len + 3);
   endtask

   task automatic set_students(input logic [6:0] rm, input logic [20:0] cr);
      reg_mask = rm;
      for (int i = 1; i <= 7; i++) cred[i] = cr[3*(i-1) +: 3];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 1; i <= 7; i++) cred[i] = 3'd0;
      repeat (2) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      // Students 2, 5, 6 with credits 1, 0, 6.
      set_students(7'b0110010, {3'd0, 3'd6, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0});
      use_stub = 1'b0;
      run_read("three", 3'd3, 7'b0010010, 3'd2, 1'b0, 1'b0, 5);
      run_read("thr0", 3'd0, 7'd0, 3'd0, 1'b0, 1'b0, 3);

      // All seven students with zero credit, back-to-back reads.
      set_students(7'h7F, 21'd0);
      run_read("all7", 3'd1, 7'h7F, 3'd7, 1'b0, 1'b0, 10);
      run_read("all7_again", 3'd1, 7'h7F, 3'd7, 1'b0, 1'b0, 10);

      // Repeating ID 3 with no end flag.
      stub_q.delete();
      stub_fill = 3'd3;
      use_stub = 1'b1;
      run_read("dup_to", 3'd2, 7'b0000100, 3'd1, 1'b1, 1'b1, TIMEOUT + 3);

      // Reset in the middle of a list read.
      use_stub = 1'b0;
      @(negedge CLK);
      start = 1'b1;
      threshold = 3'd1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b0;
      @(posedge CLK); #1;
      check_reset_outputs("midreset");
      repeat (2) begin
         @(posedge CLK); #1;
         check("midreset_no_done", done, 0);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      check("post_reset_no_done", done, 0);
      run_read("after_reset", 3'd1, 7'h7F, 3'd7, 1'b0, 1'b0, 10);

      // Randomized credit-block reads.
      for (int t = 0; t < 8; t++) begin
         set_students(7'($urandom), 21'($urandom));
         credit_read("rnd_credit", 3'($urandom));
      end

      // Randomized raw streams, including duplicates and timeouts.
      for (int t = 0; t < 10; t++) begin
         stub_read("rnd_stub", $urandom_range(0, 12));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/credit_warn_reader.md
# credit_warn_reader

Reader side of the credit-system low-balance warning list. On `start` it takes ownership of the credit block's command port, drives mode 3 with a threshold, and consumes the one-ID-per-clock `idOutput` stream until `endOfListWar`. It then drives one mode-0 cycle to clear the per-student listed flags and presents the warned set as a bitmask plus count. A top-level mux routes this block's command outputs to the credit block while `busy` is high.

## Interface
Parameters:
- TIMEOUT, 9, max valid list samples before abort; 7 IDs + 1 end + 1 margin.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- start  in  1  begin a list read; sampled only in IDLE.
- threshold  in  3  credit threshold; latched at start.
- idOutput  in  3  from credit block; registered list ID, 0 = none.
- endOfListWar  in  1  from credit block; end-of-list flag.
- mode  out  2  command mode to credit block.
- credit  out  3  credit/threshold to credit block.
- studentID  out  3  always 0; ID 0 never registers in mode 0.
- incTime  out  1  always 0.
- busy  out  1  high in LIST and CLEAR.
- done  out  1  one-cycle pulse when a read completes.
- warnMask  out  7  bit i-1 set if student i was listed.
- warnCount  out  3  number of distinct listed students.
- dupErr  out  1  an already-set ID was reported again.
- timeoutErr  out  1  no end flag within TIMEOUT samples.

## Operation
- States: IDLE, LIST, CLEAR, DONE. All outputs are registered.
- IDLE: mode=0, credit=0. This clears the credit block's listed flags every edge. Transitions:
  - start=1: go to LIST; mode=3; credit=threshold; clear warnMask, warnCount, dupErr, timeoutErr and the sample counter; set skip=1.
  - start=0: stay in IDLE.
- LIST:
  - First edge: clear skip and ignore inputs. The credit block is still emitting the prior mode-0 result.
  - Each later edge is one valid sample; increment the sample counter.
  - endOfListWar=1: go to CLEAR; mode=0; credit=0. idOutput is ignored on that edge; end has priority.
  - Else idOutput≠0, bit not set: set bit idOutput-1 in warnMask; warnCount+1.
  - Else idOutput≠0, bit already set: set dupErr; mask and count unchanged.
  - Else idOutput=0: no effect.
  - Sample counter reaches TIMEOUT with no end: set timeoutErr; go to CLEAR.
- CLEAR: hold mode=0 for one edge so the credit block clears its flags, then go to DONE.
- DONE: done=1 for this cycle only; next edge goes to IDLE.
- start is ignored outside IDLE.
- warnMask, warnCount and the error flags hold until the next accepted start or reset.
- Reset while low:
  - state=IDLE, mode=0, credit=0, studentID=0, incTime=0.
  - busy=0, done=0, warnMask=0, warnCount=0, dupErr=0, timeoutErr=0.
  - Reset mid-LIST aborts without done. Leftover flags in the credit block are cleared by the IDLE mode-0 drive on the first edge after reset releases.

## Timing
- Edge numbering:
  - E0: start accepted; mode=3 is visible from here.
  - E1: credit block produces its first list result; this block skips.
  - With K warned students, the credit block emits IDs at E1..EK and end at E(K+1).
  - This block records the IDs at E2..E(K+1) and sees end at E(K+2), then enters CLEAR.
  - E(K+3): the credit block sees mode 0 and enters DONE.
  - done is high during the cycle after E(K+3); IDLE resumes at E(K+4).
- Latency from start to done: K+3 edges.
- busy is high from after E0 through after E(K+2).
- Timeout abort: done follows TIMEOUT+3 edges after start.
- warnCount is 3 bits and cannot overflow; at most 7 distinct IDs.

## Test plan
- Students 2, 5, 6 registered with remaining credits 1, 0, 6; threshold=3; start -> warnMask=7'b0010010, warnCount=2, done pulse 5 edges after start, no errors.
- threshold=0 -> end at E1; done 3 edges after start; warnMask=0, warnCount=0.
- All 7 students registered with 0 credits; threshold=1 -> warnMask=7'h7F, warnCount=7, done at E10.
- Back-to-back reads with the same threshold -> second read gives an identical result, proving the CLEAR/IDLE mode-0 flag clear works.
- Stub stream repeating idOutput=3 with no end -> dupErr=1, timeoutErr=1, warnCount=1, done at TIMEOUT+3 edges after start.
- RST_N low during LIST -> next edge: all outputs at reset values, no done; a subsequent read returns the correct result.
